// File: rtl/wb_mem_tester.sv
// wb_mem_tester: Wishbone classic initiator that writes a seeded pattern to a
// block of consecutive words, reads it back, and reports mismatches/timeouts.
module wb_mem_tester #(
  parameter int          CNT_W   = 16,
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] STEP    = 32'h9E3779B9
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      seed,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_addr
);

  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, FIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state, next_state;
  logic [31:0]      base_r, seed_r, adr_r, dat_r, first_err_r;
  logic [CNT_W-1:0] count_r, idx_r, err_r;
  logic [7:0]       tmo_cnt;
  logic             done_r, pass_r, timeout_r;
  logic             accept, bus_ack, tmo_hit, enter_fin;
  logic             in_xfer, phase_end, rd_mismatch;

  assign in_xfer     = (state == WR) || (state == RD);
  assign phase_end   = (idx_r == count_r);
  assign rd_mismatch = (state == RD) && bus_ack && (wbm_dat_i != dat_r);

  // Sequence the write pass, the read pass and the single-cycle finish.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    bus_ack    = 1'b0;
    tmo_hit    = 1'b0;
    enter_fin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (word_count == '0) ? FIN : WR;
        end
      end
      WR, RD: begin
        if (wbm_ack_i) begin
          bus_ack    = 1'b1;
          next_state = (state == WR) ? WR_GAP : RD_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = FIN;
        end
      end
      WR_GAP:  next_state = phase_end ? RD : WR;
      RD_GAP:  next_state = phase_end ? FIN : RD;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if ((next_state == FIN) && (state != FIN)) begin
      enter_fin = 1'b1;
    end
  end

  // State register; reset abandons any open bus cycle immediately.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address/pattern accumulators, word index, ack timer and result registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      base_r      <= '0;
      seed_r      <= '0;
      adr_r       <= '0;
      dat_r       <= '0;
      count_r     <= '0;
      idx_r       <= '0;
      err_r       <= '0;
      first_err_r <= '0;
      tmo_cnt     <= '0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      tmo_cnt <= (in_xfer && !wbm_ack_i) ? tmo_cnt + 8'd1 : 8'd0;
      if (accept) begin
        base_r      <= base_addr & 32'hFFFF_FFFC;
        adr_r       <= base_addr & 32'hFFFF_FFFC;
        seed_r      <= seed;
        dat_r       <= seed;
        count_r     <= word_count;
        idx_r       <= '0;
        err_r       <= '0;
        first_err_r <= '0;
        done_r      <= 1'b0;
        pass_r      <= 1'b0;
        timeout_r   <= 1'b0;
      end
      if (bus_ack) begin
        adr_r <= adr_r + 32'd4;
        dat_r <= dat_r + STEP;
        idx_r <= idx_r + CNT_W'(1);
      end
      if (((state == WR_GAP) || (state == RD_GAP)) && phase_end) begin
        adr_r <= base_r;
        dat_r <= seed_r;
        idx_r <= '0;
      end
      if (rd_mismatch) begin
        if (err_r != '1) begin
          err_r <= err_r + CNT_W'(1);
        end
        if (err_r == '0) begin
          first_err_r <= adr_r;
        end
      end
      if (tmo_hit) begin
        timeout_r <= 1'b1;
      end
      if (enter_fin) begin
        done_r <= 1'b1;
        pass_r <= accept || (!tmo_hit && !timeout_r && (err_r == '0));
      end
    end
  end

  assign wbm_cyc_o      = in_xfer;
  assign wbm_stb_o      = in_xfer;
  assign wbm_we_o       = (state == WR);
  assign wbm_sel_o      = in_xfer ? 4'hF : 4'h0;
  assign wbm_adr_o      = adr_r;
  assign wbm_dat_o      = dat_r;
  assign busy           = (state == WR) || (state == WR_GAP) ||
                          (state == RD) || (state == RD_GAP);
  assign done           = done_r;
  assign pass           = pass_r;
  assign timeout        = timeout_r;
  assign err_count      = err_r;
  assign first_err_addr = first_err_r;

endmodule

// File: tb/tb_wb_mem_tester.sv
// tb_wb_mem_tester: directed tests of wb_mem_tester against a small Wishbone
// responder and a transaction-level model of the expected bus traffic.
module tb_wb_mem_tester;

  localparam int          CNT_W      = 16;
  localparam int          TB_TIMEOUT = 255;
  localparam logic [31:0] TB_STEP    = 32'h9E3779B9;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      seed;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o;
  logic             wbm_ack_i = 1'b0;
  logic [31:0]      wbm_dat_i = '0;
  logic             busy, done, pass, timeout;
  logic [CNT_W-1:0] err_count;
  logic [31:0]      first_err_addr;

  wb_mem_tester #(.CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT), .STEP(TB_STEP)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Responder controls and storage
  logic        never_ack = 1'b0;
  logic        rand_waits = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_adr = '0;
  logic [31:0] mem [0:31];
  int          wait_cnt = 0;
  int          wait_tgt = 0;

  // Model / scoreboard state
  logic        chk_en = 1'b0;
  logic [31:0] exp_base = '0, exp_seed = '0;
  int          exp_n = 0;
  int          tx_idx = 0;
  int          model_err = 0;
  logic [31:0] model_first = '0;
  logic        model_timeout = 1'b0;
  int          busy_cycles = 0;
  int          stb_run = 0, last_stb_run = 0;
  int          gap_phase = 0;
  logic        prev_stb_noack = 1'b0;
  logic [31:0] obs_wadr [0:7];
  logic [31:0] obs_wdat [0:7];
  int          k_cur;
  logic        wr_cur;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] modelAdr(input int k);
    return (exp_base & 32'hFFFF_FFFC) + 32'(k) * 32'd4;
  endfunction

  function automatic logic [31:0] modelData(input int k);
    return exp_seed + 32'(k) * TB_STEP;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wishbone responder: ack after a programmable number of wait states.
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_ack_i <= 1'b0;
      wait_cnt  <= 0;
    end else if (wbm_ack_i) begin
      wbm_ack_i <= 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o && !never_ack) begin
      if (wait_cnt >= wait_tgt) begin
        wbm_ack_i <= 1'b1;
        wait_cnt  <= 0;
        wait_tgt  <= rand_waits ? int'($urandom_range(10, 0)) : 0;
        if (wbm_we_o) begin
          mem[wbm_adr_o[6:2]] <= wbm_dat_o;
        end
        wbm_dat_i <= (corrupt_en && (wbm_adr_o == corrupt_adr)) ?
                     32'hDEADBEEF : mem[wbm_adr_o[6:2]];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Compare process: check every cycle of bus traffic against the model.
  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      if (busy) busy_cycles++;
      if (gap_phase == 1) begin
        checkOutput("gap_idle", wbm_stb_o, 1'b0);
      end else if (gap_phase == 2 && tx_idx < 2 * exp_n) begin
        checkOutput("gap_resume", wbm_stb_o, 1'b1);
      end
      gap_phase = (gap_phase == 1) ? 2 : 0;
      if (wbm_stb_o) begin
        checkOutput("cyc_sel_busy", {wbm_cyc_o, wbm_sel_o, busy}, {1'b1, 4'hF, 1'b1});
        if (tx_idx >= 2 * exp_n) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_tx: got stb=1 at tx %0d expected no transaction", tx_idx);
        end else begin
          k_cur  = tx_idx % exp_n;
          wr_cur = (tx_idx < exp_n);
          checkOutput("bus_adr", wbm_adr_o, modelAdr(k_cur));
          checkOutput("bus_we", wbm_we_o, wr_cur);
          if (wr_cur) checkOutput("bus_wdat", wbm_dat_o, modelData(k_cur));
          if (wbm_ack_i) begin
            if (wr_cur) begin
              if (k_cur < 8) begin
                obs_wadr[k_cur] = wbm_adr_o;
                obs_wdat[k_cur] = wbm_dat_o;
              end
            end else if (wbm_dat_i !== modelData(k_cur)) begin
              if (model_err == 0) model_first = modelAdr(k_cur);
              model_err++;
            end
            tx_idx++;
            gap_phase = 1;
            stb_run   = 0;
          end else begin
            stb_run++;
          end
        end
        prev_stb_noack = !wbm_ack_i;
      end else begin
        checkOutput("idle_cyc_sel", {wbm_cyc_o, wbm_sel_o}, 5'b0);
        if (prev_stb_noack) begin
          last_stb_run  = stb_run;
          model_timeout = 1'b1;
          checkOutput("timeout_len", stb_run, TB_TIMEOUT);
          stb_run = 0;
        end
        prev_stb_noack = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] base_v, input int count_v,
                               input logic [31:0] seed_v);
    @(posedge wb_clk_i); #1;
    exp_base = base_v; exp_seed = seed_v; exp_n = count_v;
    tx_idx = 0; model_err = 0; model_first = '0; model_timeout = 1'b0;
    busy_cycles = 0; stb_run = 0; last_stb_run = 0; gap_phase = 0;
    prev_stb_noack = 1'b0; chk_en = 1'b1;
    base_addr = base_v; word_count = CNT_W'(count_v); seed = seed_v;
    start = 1'b1;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_wait: got done=0 after %0d cycles expected done=1", n);
    end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_done_busy"}, {done, busy}, 2'b10);
    checkOutput({tag, "_pass"}, pass, (model_err == 0) && !model_timeout);
    checkOutput({tag, "_timeout"}, timeout, model_timeout);
    checkOutput({tag, "_err_count"}, err_count, model_err);
    checkOutput({tag, "_first_err"}, first_err_addr, model_first);
    if (!model_timeout) checkOutput({tag, "_tx_count"}, tx_idx, 2 * exp_n);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bus"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o}, '0);
    checkOutput({tag, "_wdat"}, wbm_dat_o, '0);
    checkOutput({tag, "_status"}, {busy, done, pass, timeout, err_count, first_err_addr}, '0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      obs_wadr[i] = '0;
      obs_wdat[i] = '0;
    end
    wb_rst_i = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkAllZero("reset");
    wb_rst_i = 1'b0;

    $display("[TB] zero-wait 4-word test");
    applyStimulus(32'h100, 4, 32'h0);
    waitDone(200);
    checkStatus("basic");
    checkOutput("basic_pass_lit", pass, 1'b1);
    checkOutput("basic_busy_cycles", busy_cycles, 24);
    checkOutput("basic_wdat1", obs_wdat[1], 32'h9E3779B9);
    checkOutput("basic_wdat3", obs_wdat[3], 32'hDAA66D2B);
    // 0x108 lands in responder word 2
    checkOutput("basic_mem108", mem[2], 32'h3C6EF372);

    $display("[TB] corrupted read test");
    corrupt_en = 1'b1; corrupt_adr = 32'h108;
    applyStimulus(32'h100, 4, 32'h0);
    waitDone(200);
    checkStatus("corrupt");
    checkOutput("corrupt_err_lit", err_count, 16'd1);
    checkOutput("corrupt_first_lit", first_err_addr, 32'h108);
    checkOutput("corrupt_pass_lit", pass, 1'b0);
    corrupt_en = 1'b0;

    $display("[TB] no-ack timeout test");
    never_ack = 1'b1;
    applyStimulus(32'h200, 2, 32'h1);
    waitDone(400);
    checkStatus("tmo");
    checkOutput("tmo_run_lit", last_stb_run, 255);
    checkOutput("tmo_flags_lit", {timeout, pass, err_count}, {1'b1, 1'b0, 16'd0});
    never_ack = 1'b0;

    $display("[TB] zero-count test");
    applyStimulus(32'h300, 0, 32'h5);
    checkOutput("zero_done_pass_busy", {done, pass, busy}, 3'b110);
    repeat (4) @(posedge wb_clk_i);
    #1;
    checkStatus("zero");

    $display("[TB] address wrap test with ignored start");
    applyStimulus(32'hFFFF_FFF8, 3, 32'h55);
    repeat (4) @(posedge wb_clk_i);
    #1;
    base_addr = 32'h0; word_count = CNT_W'(1); start = 1'b1;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
    waitDone(200);
    checkStatus("wrap");
    checkOutput("wrap_adr0_lit", obs_wadr[0], 32'hFFFF_FFF8);
    checkOutput("wrap_adr2_lit", obs_wadr[2], 32'h0000_0000);

    $display("[TB] random wait-state test");
    rand_waits = 1'b1;
    applyStimulus(32'h2000, 8, 32'h12345678);
    waitDone(2000);
    checkStatus("rand");

    $display("[TB] reset during read test");
    applyStimulus(32'h400, 6, 32'hCAFEF00D);
    n = 0;
    while (!(tx_idx >= 7 && wbm_stb_o) && n < 1000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (!(tx_idx >= 7 && wbm_stb_o)) begin
      checks++;
      failures++;
      $display("[TB] FAIL midread_wait: got tx %0d expected a read in progress", tx_idx);
    end
    chk_en = 1'b0;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    checkAllZero("midreset");
    wb_rst_i = 1'b0;
    rand_waits = 1'b0;
    applyStimulus(32'h40, 3, 32'hFFFF_FFFF);
    waitDone(200);
    checkStatus("after_reset");
    checkOutput("after_reset_pass_lit", pass, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
